// File: rtl/cordic_vectoring_engine.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vectoring_engine
// Description : Sequential CORDIC in vectoring mode; one micro-rotation per
//               clock, returns gain-compensated magnitude and atan2(y, x).
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vectoring_engine #(
    parameter int FIXED_WIDTH = 16,
    parameter int ITERATIONS  = 9,
    parameter int GAIN_COMP   = 4975
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [FIXED_WIDTH-1:0] x_in,
    input  logic signed [FIXED_WIDTH-1:0] y_in,
    output logic                          busy,
    output logic                          done,
    output logic signed [FIXED_WIDTH-1:0] magnitude,
    output logic signed [FIXED_WIDTH-1:0] angle
);

    localparam int c_frac  = FIXED_WIDTH - 3;
    localparam int c_up    = (c_frac >= 13) ? (c_frac - 13) : 0;
    localparam int c_dn    = (c_frac <  13) ? (13 - c_frac) : 0;
    localparam logic [3:0] c_last = 4'(ITERATIONS - 1);
    localparam logic signed [FIXED_WIDTH-1:0] c_gain = FIXED_WIDTH'(GAIN_COMP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    // Constants below are written in Q2.13 and rescaled to the configured width.
    function automatic logic signed [FIXED_WIDTH-1:0] f_q13(input int v);
        int t;
        t = (v <<< c_up) >>> c_dn;
        return FIXED_WIDTH'(t);
    endfunction

    function automatic logic signed [FIXED_WIDTH-1:0] f_atan(input logic [3:0] i);
        int t;
        case (i)
            4'd0:    t = 6434;
            4'd1:    t = 3798;
            4'd2:    t = 2007;
            4'd3:    t = 1019;
            4'd4:    t = 511;
            4'd5:    t = 256;
            4'd6:    t = 128;
            4'd7:    t = 64;
            4'd8:    t = 32;
            default: t = 8192 >>> int'(i);
        endcase
        return f_q13(t);
    endfunction

    localparam logic signed [FIXED_WIDTH-1:0] c_half_pi = f_q13(12868);

    state_t                          r_state;
    logic signed [FIXED_WIDTH-1:0]   r_x;
    logic signed [FIXED_WIDTH-1:0]   r_y;
    logic signed [FIXED_WIDTH-1:0]   r_z;
    logic [3:0]                      r_cnt;

    logic signed [FIXED_WIDTH-1:0]   w_xs;
    logic signed [FIXED_WIDTH-1:0]   w_ys;
    logic signed [FIXED_WIDTH-1:0]   w_atan;
    logic signed [2*FIXED_WIDTH-1:0] w_prod;

    always_comb begin
        w_xs   = r_x >>> r_cnt;
        w_ys   = r_y >>> r_cnt;
        w_atan = f_atan(r_cnt);
        w_prod = r_x * c_gain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            magnitude <= '0;
            angle     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Pre-rotate left-half-plane vectors by +/-pi/2 so
                        // the iterations only need to cover +/-pi/2.
                        if (!x_in[FIXED_WIDTH-1]) begin
                            r_x <= x_in;
                            r_y <= y_in;
                            r_z <= '0;
                        end else if (!y_in[FIXED_WIDTH-1]) begin
                            r_x <= y_in;
                            r_y <= -x_in;
                            r_z <= c_half_pi;
                        end else begin
                            r_x <= -y_in;
                            r_y <= x_in;
                            r_z <= -c_half_pi;
                        end
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (!r_y[FIXED_WIDTH-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_last) begin
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    magnitude <= FIXED_WIDTH'(w_prod >>> c_frac);
                    angle     <= r_z;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
